alu8_seq: RTL
=============

// Module: alu8_seq
// PURPOSE
//  Sequencer for one alu8 instance (8-bit add/sub, ovf flag). Accepts ADD, SUB and
//  unsigned 8x8 MUL requests over a valid/ready handshake and drives the alu8 each cycle.
//  MUL is shift-and-add over 8 ALU passes. Sits between the decode logic and the ALU.
// PARAMETERS
//  CLR_ON_ACCEPT  1  1: result/flag cleared to 0 on request accept; 0: hold last value
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   block can accept (high only in IDLE)
//  req_op     in   2   00 ADD, 01 SUB, 10 MUL, 11 reserved (treated as ADD)
//  req_a      in   8   operand A / multiplicand
//  req_b      in   8   operand B / multiplier
//  resp_valid out  1   result valid, held until resp_ready
//  resp_ready in   1   consumer takes result
//  result     out  16  ADD/SUB: {8'h00,sum}; MUL: unsigned product
//  flag       out  1   ADD/SUB: alu8 ovf; MUL: always 0
//  busy       out  1   high in CALC
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, counter 0, result 16'h0000, flag 0,
//    resp_valid 0, busy 0, req_ready 0 while rst_n low, 1 after release.
//  - FSM: IDLE -> CALC on req_valid&&req_ready (operands/op registered on that edge);
//    CALC -> DONE after last pass; DONE -> IDLE on resp_valid&&resp_ready.
//  - req_ready = (state==IDLE). Inputs ignored outside the accept edge.
//  - ADD/SUB: one CALC cycle; alu8 a=A_reg, b=B_reg, sub=op[0]; sum/ovf captured into
//    result[7:0]/flag at end of that cycle; result[15:8]=0.
//  - MUL: regs hi[7:0]=0, lo[7:0]=B_reg, cnt=0. Each CALC cycle: alu8 a=hi, b=A_reg,
//    sub=0. If lo[0]: {c,s}={carry,sum} else {c,s}={0,hi}.
//    carry derived locally as (sum < hi), not from ovf.
//    Then {hi,lo} <= {c,s,lo[7:1]}; cnt++. Exit after 8th pass (cnt==7): result={hi,lo}.
//  - Latency: accept at edge T; ADD/SUB resp_valid high after T+1, MUL after T+8.
//    Next accept earliest one cycle after response handshake (DONE->IDLE->accept).
//  - alu8 sub driven 0 outside ADD/SUB CALC cycle; alu8 outputs ignored outside CALC.
//  - resp_valid held with result/flag stable while resp_ready=0 (no overwrite).
//  - resp_ready while resp_valid=0: no effect.
//  - CLR_ON_ACCEPT=1: result/flag zero from accept edge until completion.
//  - Reset mid-CALC or mid-DONE: operation discarded, no response, outputs to reset values.
//  - Width: all arithmetic mod 2^8 per pass; MUL product never exceeds 16'hFE01.
// TESTING
//  1 ADD 123+8 -> resp_valid at T+1, result 16'h0083, flag per alu8 ovf (0).
//  2 SUB 5-9 -> result 16'h00FC, flag = alu8 ovf; MUL 255*255 -> result 16'hFE01 at T+8.
//  3 MUL 0*200 and 200*1 -> 16'h0000 and 16'h00C8; flag 0; busy high exactly 8 cycles.
//  4 Backpressure: resp_ready=0 for 5 cycles after MUL 12*13 -> result 16'h009C held,
//    req_ready 0 throughout; new req_valid ignored until after handshake.
//  5 Operand change: alter req_a/req_b during CALC of MUL 17*3 -> result 16'h0033.
//  6 Async reset asserted mid-MUL (cnt=4) -> all outputs reset immediately; next
//    ADD 1+1 after release -> 16'h0002.
//  Compare against a reference model over 1000 random ops with random resp_ready stalls.

Source files
------------

// File: rtl/alu8_seq_if.sv
// Request/response bundle between decode logic and the alu8 sequencer.
// master = requester/consumer side, slave = sequencer side.
interface alu8_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] result;
    logic        flag;
    logic        busy;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, result, flag, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, result, flag, busy
    );
endinterface

// File: rtl/alu8_seq.sv
// Sequencer driving one 8-bit add/sub ALU: ADD/SUB in one pass, unsigned 8x8 MUL by 8 shift-and-add passes.
// Latency: accept at edge T, resp_valid from T+1 (ADD/SUB) or T+8 (MUL).
// Backpressure: result held in DONE until resp_ready; req_ready only in IDLE, so no new accept meanwhile.
module alu8_seq #(
    parameter bit CLR_ON_ACCEPT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu8_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [7:0]  a_reg;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [2:0]  cnt;
    logic        is_mul;
    logic        is_sub;
    logic [15:0] result_q;
    logic        flag_q;
    logic        resp_valid_q;
    logic        busy_q;

    // alu8: ovf is the unsigned out-of-range bit (carry on add, borrow on sub)
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_sub;
    logic [7:0]  alu_sum;
    logic        alu_ovf;
    logic [8:0]  alu_wide;

    logic        mul_carry;
    logic        step_c;
    logic [7:0]  step_s;
    logic [15:0] mul_next;

    always_comb begin
        alu_a    = is_mul ? hi : a_reg;
        alu_b    = is_mul ? a_reg : lo;
        alu_sub  = (state == CALC) && !is_mul && is_sub;
        alu_wide = alu_sub ? ({1'b0, alu_a} - {1'b0, alu_b})
                           : ({1'b0, alu_a} + {1'b0, alu_b});
        alu_sum  = alu_wide[7:0];
        alu_ovf  = alu_wide[8];
    end

    // Multiply step: carry recovered from the wrapped sum rather than from ovf
    always_comb begin
        mul_carry = (alu_sum < hi);
        step_c    = lo[0] ? mul_carry : 1'b0;
        step_s    = lo[0] ? alu_sum : hi;
        mul_next  = {step_c, step_s, lo[7:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_reg        <= 8'h00;
            hi           <= 8'h00;
            lo           <= 8'h00;
            cnt          <= 3'd0;
            is_mul       <= 1'b0;
            is_sub       <= 1'b0;
            result_q     <= 16'h0000;
            flag_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_reg  <= bus.req_a;
                        lo     <= bus.req_b;
                        hi     <= 8'h00;
                        cnt    <= 3'd0;
                        is_mul <= (bus.req_op == 2'b10);
                        is_sub <= (bus.req_op == 2'b01);
                        busy_q <= 1'b1;
                        state  <= CALC;
                        if (CLR_ON_ACCEPT) begin
                            result_q <= 16'h0000;
                            flag_q   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    if (!is_mul) begin
                        result_q     <= {8'h00, alu_sum};
                        flag_q       <= alu_ovf;
                        busy_q       <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state        <= DONE;
                    end else begin
                        {hi, lo} <= mul_next;
                        cnt      <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            result_q     <= mul_next;
                            flag_q       <= 1'b0;
                            busy_q       <= 1'b0;
                            resp_valid_q <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE) && rst_n;
    assign bus.resp_valid = resp_valid_q;
    assign bus.result     = result_q;
    assign bus.flag       = flag_q;
    assign bus.busy       = busy_q;
endmodule
